// File: rtl/led_mode_scheduler.sv
// -----------------------------------------------------------------------------
// led_mode_scheduler
//
// Sequencing controller for the LED pattern generator. It owns the step-rate
// prescaler and selects the active pattern mode. The mode comes either from the
// manual switches or from a fixed ten-entry playlist. Every mode change goes
// through a one-cycle LOAD state that emits a restart pulse, so the generator
// begins each pattern from a clean state.
//
// Parameters:
//   TICK_DIV      clk cycles per step pulse (2 .. 2^31-1)
//   DWELL_STEPS   step pulses spent on each playlist entry in auto mode (>= 1)
//   DEBOUNCE_CYC  cycles a synchronised sw value must stay stable before it is
//                 accepted; only used when LED_SCHED_DEBOUNCE_EN is defined
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset
//   sw        in   4  manual mode request (asynchronous)
//   auto_en   in   1  1 = playlist mode, 0 = manual mode (asynchronous)
//   pause     in   1  freezes prescaler and dwell counter (asynchronous)
//   mode      out  4  active mode code for the pattern generator
//   step      out  1  one-cycle step enable
//   restart   out  1  one-cycle pattern-state clear pulse
//   play_idx  out  4  current playlist index, 0..9
//
// Build option:
//   LED_SCHED_DEBOUNCE_EN  when defined, a debounce stage of DEBOUNCE_CYC cycles
//                          sits between the sw synchroniser and the mode logic.
//                          When undefined, no debounce counter is built.
// -----------------------------------------------------------------------------
module led_mode_scheduler #(
  parameter int TICK_DIV     = 5000000,
  parameter int DWELL_STEPS  = 32,
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       auto_en,
  input  logic       pause,
  output logic [3:0] mode,
  output logic       step,
  output logic       restart,
  output logic [3:0] play_idx
);

  localparam logic [3:0]  CLEAR_CODE = 4'b1111;
  localparam logic [3:0]  LAST_IDX   = 4'd9;
  localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_STEPS - 1);

  // Reject parameter values that would make the counters meaningless.
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("led_mode_scheduler: TICK_DIV must be at least 2");
  end
  if (DWELL_STEPS < 1) begin : g_bad_dwell_steps
    $error("led_mode_scheduler: DWELL_STEPS must be at least 1");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce_cyc
    $error("led_mode_scheduler: DEBOUNCE_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Playlist order, index 0..9.
  function automatic logic [3:0] playlist_code(input logic [3:0] idx);
    case (idx)
      4'd0:    playlist_code = 4'b0000;
      4'd1:    playlist_code = 4'b1000;
      4'd2:    playlist_code = 4'b0100;
      4'd3:    playlist_code = 4'b0010;
      4'd4:    playlist_code = 4'b0001;
      4'd5:    playlist_code = 4'b1100;
      4'd6:    playlist_code = 4'b1010;
      4'd7:    playlist_code = 4'b1001;
      4'd8:    playlist_code = 4'b1110;
      4'd9:    playlist_code = 4'b1101;
      default: playlist_code = CLEAR_CODE;
    endcase
  endfunction

  // Legal codes pass through; any other switch pattern becomes the clear code.
  function automatic logic [3:0] map_sw(input logic [3:0] v);
    case (v)
      4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
      4'b1100, 4'b1010, 4'b1001, 4'b1110, 4'b1101,
      4'b1111: map_sw = v;
      default: map_sw = CLEAR_CODE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the asynchronous inputs
  // ---------------------------------------------------------------------------
  logic [3:0] sw_s1_q, sw_s2_q;
  logic       auto_s1_q, auto_s2_q;
  logic       pause_s1_q, pause_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q    <= 4'b0000;
      sw_s2_q    <= 4'b0000;
      auto_s1_q  <= 1'b0;
      auto_s2_q  <= 1'b0;
      pause_s1_q <= 1'b0;
      pause_s2_q <= 1'b0;
    end else begin
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      auto_s1_q  <= auto_en;
      auto_s2_q  <= auto_s1_q;
      pause_s1_q <= pause;
      pause_s2_q <= pause_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted switch value
  // ---------------------------------------------------------------------------
  logic [3:0] sw_acc;

`ifdef LED_SCHED_DEBOUNCE_EN
  localparam logic [31:0] DB_TARGET = 32'(DEBOUNCE_CYC);

  logic [3:0]  db_cand_q, db_cand_d;
  logic [3:0]  sw_acc_q, sw_acc_d;
  logic [31:0] db_cnt_q, db_cnt_d;

  // db_cnt counts the cycles (including the current one) for which the
  // synchronised value has equalled the candidate; it saturates at the target
  // so a long-held value never wraps back below it.
  always_comb begin
    db_cand_d = sw_s2_q;
    sw_acc_d  = sw_acc_q;
    if (sw_s2_q != db_cand_q) begin
      db_cnt_d = 32'd1;
    end else if (db_cnt_q >= DB_TARGET) begin
      db_cnt_d = db_cnt_q;
    end else begin
      db_cnt_d = db_cnt_q + 32'd1;
    end
    if (db_cnt_d >= DB_TARGET) begin
      sw_acc_d = sw_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cand_q <= 4'b0000;
      sw_acc_q  <= 4'b0000;
      db_cnt_q  <= 32'd0;
    end else begin
      db_cand_q <= db_cand_d;
      sw_acc_q  <= sw_acc_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  assign sw_acc = sw_acc_q;
`else
  assign sw_acc = sw_s2_q;
`endif

  // ---------------------------------------------------------------------------
  // Sequencing FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic        step_q, step_d;
  logic        restart_q, restart_d;
  logic [3:0]  play_idx_q, play_idx_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] dwell_q, dwell_d;
  // auto_en value the current mode was loaded under; any difference from the
  // synchronised auto_en is a change request, even one arriving during LOAD.
  logic        auto_cur_q, auto_cur_d;
  logic        change_req;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    step_d     = 1'b0;
    restart_d  = 1'b0;
    play_idx_d = play_idx_q;
    presc_d    = presc_q;
    dwell_d    = dwell_q;
    auto_cur_d = auto_cur_q;

    change_req = (auto_s2_q != auto_cur_q) ||
                 (!auto_cur_q && (map_sw(sw_acc) != mode_q));

    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
      end

      // Pause is deliberately ignored here so a pending change always restarts.
      ST_LOAD: begin
        auto_cur_d = auto_s2_q;
        mode_d     = auto_s2_q ? playlist_code(play_idx_q) : map_sw(sw_acc);
        restart_d  = 1'b1;
        presc_d    = 32'd0;
        dwell_d    = 32'd0;
        state_d    = ST_RUN;
      end

      ST_RUN: begin
        if (change_req) begin
          // Change wins over a coincident step; the step is dropped.
          state_d = ST_LOAD;
        end else if (!pause_s2_q) begin
          if (presc_q == TICK_LAST) begin
            presc_d = 32'd0;
            step_d  = 1'b1;
            if (auto_cur_q) begin
              if (dwell_q == DWELL_LAST) begin
                // Final dwell step still fires; LOAD follows next cycle.
                dwell_d    = 32'd0;
                play_idx_d = (play_idx_q == LAST_IDX) ? 4'd0 : play_idx_q + 4'd1;
                state_d    = ST_LOAD;
              end else begin
                dwell_d = dwell_q + 32'd1;
              end
            end
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= CLEAR_CODE;
      step_q     <= 1'b0;
      restart_q  <= 1'b0;
      play_idx_q <= 4'd0;
      presc_q    <= 32'd0;
      dwell_q    <= 32'd0;
      auto_cur_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      restart_q  <= restart_d;
      play_idx_q <= play_idx_d;
      presc_q    <= presc_d;
      dwell_q    <= dwell_d;
      auto_cur_q <= auto_cur_d;
    end
  end

  assign mode     = mode_q;
  assign step     = step_q;
  assign restart  = restart_q;
  assign play_idx = play_idx_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_led_mode_scheduler
//
// Drives led_mode_scheduler with directed scenarios followed by randomised
// stimulus and compares every output on every cycle against a behavioural
// model of the scheduler's rules (input delay line, step counting, playlist
// walk). Prints one line per mode load and a final summary line.
// -----------------------------------------------------------------------------
module tb_led_mode_scheduler;

  localparam int TD = 4;   // TICK_DIV
  localparam int DW = 3;   // DWELL_STEPS
  localparam int DB = 8;   // DEBOUNCE_CYC

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       auto_en;
  logic       pause;
  logic [3:0] mode;
  logic       step;
  logic       restart;
  logic [3:0] play_idx;

  always #5 clk = ~clk;

  led_mode_scheduler #(
    .TICK_DIV     (TD),
    .DWELL_STEPS  (DW),
    .DEBOUNCE_CYC (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .auto_en  (auto_en),
    .pause    (pause),
    .mode     (mode),
    .step     (step),
    .restart  (restart),
    .play_idx (play_idx)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_LOAD, M_RUN} mphase_t;

  logic [3:0] PLAYLIST [10] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                4'b1100, 4'b1010, 4'b1001, 4'b1110, 4'b1101};

  mphase_t    ph;
  logic [3:0] sw_h1, sw_h2;      // sw as seen one and two edges ago
  bit         a_h1, a_h2, p_h1, p_h2;
  logic [3:0] m_cand, m_acc;
  int         m_db_cnt;
  int         m_ticks, m_dwell, m_idx;
  logic [3:0] e_mode;
  bit         e_step, e_restart, m_auto_used;

  function automatic logic [3:0] model_map(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      if (PLAYLIST[i] == v) r = v;
    end
    return r;
  endfunction

  task automatic model_step();
    logic [3:0] acc_now;
    bit         chg;
    if (rst) begin
      ph = M_IDLE; e_mode = 4'b1111; e_step = 0; e_restart = 0;
      m_idx = 0; m_ticks = 0; m_dwell = 0; m_auto_used = 0;
      sw_h1 = 4'b0; sw_h2 = 4'b0; a_h1 = 0; a_h2 = 0; p_h1 = 0; p_h2 = 0;
      m_cand = 4'b0; m_acc = 4'b0; m_db_cnt = 0;
      return;
    end
`ifdef LED_SCHED_DEBOUNCE_EN
    acc_now = m_acc;
`else
    acc_now = sw_h2;
`endif
    e_step = 0;
    e_restart = 0;
    case (ph)
      M_IDLE: ph = M_LOAD;
      M_LOAD: begin
        m_auto_used = a_h2;
        e_mode = a_h2 ? PLAYLIST[m_idx] : model_map(acc_now);
        e_restart = 1;
        m_ticks = 0;
        m_dwell = 0;
        ph = M_RUN;
      end
      M_RUN: begin
        chg = (a_h2 != m_auto_used) || (!m_auto_used && model_map(acc_now) != e_mode);
        if (chg) begin
          ph = M_LOAD;
        end else if (!p_h2) begin
          m_ticks++;
          if (m_ticks == TD) begin
            m_ticks = 0;
            e_step = 1;
            if (m_auto_used) begin
              m_dwell++;
              if (m_dwell == DW) begin
                m_dwell = 0;
                m_idx = (m_idx + 1) % 10;
                ph = M_LOAD;
              end
            end
          end
        end
      end
      default: ph = M_IDLE;
    endcase
`ifdef LED_SCHED_DEBOUNCE_EN
    if (sw_h2 != m_cand) begin
      m_cand = sw_h2;
      m_db_cnt = 1;
    end else if (m_db_cnt < DB) begin
      m_db_cnt++;
    end
    if (m_db_cnt >= DB) m_acc = sw_h2;
`endif
    sw_h2 = sw_h1; sw_h1 = sw;
    a_h2 = a_h1;   a_h1 = auto_en;
    p_h2 = p_h1;   p_h1 = pause;
  endtask

  // One clock: model advances on the rising edge, DUT is sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("mode", 32'(mode), 32'(e_mode));
    check_eq("step", 32'(step), 32'(e_step));
    check_eq("restart", 32'(restart), 32'(e_restart));
    check_eq("play_idx", 32'(play_idx), 32'(m_idx));
    check_eq("step_restart_excl", 32'(step & restart), 32'd0);
    if (restart) $display("load t=%0t mode=%b play_idx=%0d auto_en=%0b", $time, mode, play_idx, auto_en);
  endtask

  int n;
  int cnt;
  bit found;
  int exp_lat;

  initial begin
    rst = 1'b1; sw = 4'b0000; auto_en = 1'b0; pause = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    check_eq("reset_mode", 32'(mode), 32'hF);
    check_eq("reset_play_idx", 32'(play_idx), 32'd0);

    // Reset release: restart on the 2nd edge with mode 0000, then steps every TD.
    rst = 1'b0;
    n = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(); n++;
      if (restart) found = 1;
    end
    check_eq("release_latency", found ? n : 99, 2);
    check_eq("release_mode", 32'(mode), 32'h0);
    n = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); n++;
      if (step) found = 1;
    end
    check_eq("first_step_gap", found ? n : 99, TD);
    repeat (12) tick();

    // Manual change 0000 -> 1100.
    sw = 4'b1100;
`ifdef LED_SCHED_DEBOUNCE_EN
    exp_lat = DB + 4;
`else
    exp_lat = 4;
`endif
    n = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(); n++;
      if (restart) found = 1;
    end
    check_eq("manual_latency", found ? n : 99, exp_lat);
    check_eq("manual_mode", 32'(mode), 32'hC);
    repeat (10) tick();

    // Illegal code maps to 1111 and then stays quiet.
    sw = 4'b0011;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (restart) found = 1;
    end
    check_eq("illegal_restart_seen", 32'(found), 32'd1);
    check_eq("illegal_mode", 32'(mode), 32'hF);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (restart) cnt++;
    end
    check_eq("illegal_hold_restarts", cnt, 0);

    // Auto mode: walk the playlist through the 9 -> 0 wrap.
    auto_en = 1'b1;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (play_idx == 4'd9) found = 1;
    end
    check_eq("auto_reach_9", 32'(found), 32'd1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (restart && play_idx == 4'd0) found = 1;
    end
    check_eq("auto_wrap_seen", 32'(found), 32'd1);
    check_eq("auto_wrap_mode", 32'(mode), 32'h0);

    // Pause for 10 cycles: no steps once it has crossed the synchroniser.
    repeat (5) tick();
    pause = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 3 && step) cnt++;
    end
    check_eq("pause_no_step", cnt, 0);
    pause = 1'b0;
    repeat (20) tick();

    // Manual glitch of 5 cycles, then back to the held value.
    auto_en = 1'b0;
    repeat (20) tick();
    sw = 4'b0100;
    repeat (5) tick();
    sw = 4'b0011;
    repeat (30) tick();

    // Randomised traffic, including occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 29) == 0) sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 249) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 59) == 0) pause = ~pause;
      tick();
    end
    rst = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
